// File: rtl/alu_wavefront_ctrl.sv
// Clocked sequencer for a self-timed dual-rail ALU: encodes single-rail requests into
// DATA wavefronts, captures the completed result, then returns the ALU to all-NULL.
module alu_wavefront_ctrl #(
    parameter int unsigned W       = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [W-1:0]     req_a,
    input  logic [W-1:0]     req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [W-1:0]     rsp_result,
    output logic             rsp_neg,
    output logic             rsp_err,
    output logic [2*W-1:0]   dr_a,
    output logic [2*W-1:0]   dr_b,
    output logic [1:0]       dr_sel0,
    output logic [1:0]       dr_sel1,
    input  logic [2*W-1:0]   dr_result,
    input  logic [1:0]       dr_neg,
    output logic             fault
);

    localparam int unsigned NP = W + 1;
    localparam int unsigned RW = 2 * NP;
    localparam int unsigned TW = 8;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EVAL   = 2'd1,
        SPACER = 2'd2
    } state_t;

    function automatic logic [2*W-1:0] dr_enc(input logic [W-1:0] v);
        logic [2*W-1:0] e;
        e = '0;
        for (int unsigned i = 0; i < W; i++) begin
            e[2*i+1] = v[i];
            e[2*i]   = ~v[i];
        end
        return e;
    endfunction

    state_t        state;
    logic [TW-1:0] timer;
    logic          op_other;
    logic [RW-1:0] s1;
    logic [RW-1:0] s2;
    logic [RW-1:0] s3;

    logic          s2_illegal;
    logic          all_data;
    logic          all_null;
    logic [W-1:0]  s2_true;

    // Return path: two-flop synchronizer plus one history stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= {dr_neg, dr_result};
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Completion detection requires agreement of s2 and s3 so a wavefront is seen settled.
    always_comb begin
        s2_illegal = 1'b0;
        all_data   = 1'b1;
        all_null   = 1'b1;
        s2_true    = '0;
        for (int unsigned i = 0; i < NP; i++) begin
            if (s2[2*i+1] && s2[2*i]) s2_illegal = 1'b1;
            if (!(s2[2*i+1] ^ s2[2*i]) || !(s3[2*i+1] ^ s3[2*i])) all_data = 1'b0;
            if (s2[2*i+1] || s2[2*i] || s3[2*i+1] || s3[2*i]) all_null = 1'b0;
        end
        for (int unsigned i = 0; i < W; i++) begin
            s2_true[i] = s2[2*i+1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            timer      <= '0;
            op_other   <= 1'b0;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_neg    <= 1'b0;
            rsp_err    <= 1'b0;
            dr_a       <= '0;
            dr_b       <= '0;
            dr_sel0    <= 2'b00;
            dr_sel1    <= 2'b00;
            fault      <= 1'b0;
        end else begin
            if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        dr_a      <= dr_enc(req_a);
                        dr_b      <= dr_enc(req_b);
                        dr_sel0   <= {req_op[0], ~req_op[0]};
                        dr_sel1   <= {req_op[1], ~req_op[1]};
                        op_other  <= req_op[1];
                        timer     <= '0;
                        req_ready <= 1'b0;
                        state     <= EVAL;
                    end
                end
                EVAL: begin
                    if (s2_illegal || all_data || timer == TMAX) begin
                        if (!s2_illegal && all_data) begin
                            rsp_result <= s2_true;
                            rsp_neg    <= s2[RW-1] & ~op_other;
                            rsp_err    <= 1'b0;
                        end else begin
                            rsp_result <= '0;
                            rsp_neg    <= 1'b0;
                            rsp_err    <= 1'b1;
                        end
                        rsp_valid <= 1'b1;
                        dr_a      <= '0;
                        dr_b      <= '0;
                        dr_sel0   <= 2'b00;
                        dr_sel1   <= 2'b00;
                        timer     <= '0;
                        state     <= SPACER;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                SPACER: begin
                    // Never leave while the ALU is non-NULL; a stuck ALU parks here with fault set.
                    if (all_null && (!rsp_valid || rsp_ready)) begin
                        timer     <= '0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end else if (timer == TMAX) begin
                        if (!all_null) fault <= 1'b1;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_wavefront_ctrl.sv
// Scoreboard bench for alu_wavefront_ctrl with a behavioural dual-rail ALU model
// that supports normal, never-completing, illegal-code and stuck-DATA behaviour.
module tb_alu_wavefront_ctrl;

    localparam int unsigned W       = 4;
    localparam int unsigned TIMEOUT = 15;
    localparam int M_NORM  = 0;
    localparam int M_NEVER = 1;
    localparam int M_ILL   = 2;
    localparam int M_STUCK = 3;

    logic           clk;
    logic           rst_n;
    logic           req_valid;
    logic           req_ready;
    logic [1:0]     req_op;
    logic [W-1:0]   req_a;
    logic [W-1:0]   req_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [W-1:0]   rsp_result;
    logic           rsp_neg;
    logic           rsp_err;
    logic [2*W-1:0] dr_a;
    logic [2*W-1:0] dr_b;
    logic [1:0]     dr_sel0;
    logic [1:0]     dr_sel1;
    logic [2*W-1:0] dr_result;
    logic [1:0]     dr_neg;
    logic           fault;

    alu_wavefront_ctrl #(.W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_neg(rsp_neg), .rsp_err(rsp_err),
        .dr_a(dr_a), .dr_b(dr_b), .dr_sel0(dr_sel0), .dr_sel1(dr_sel1),
        .dr_result(dr_result), .dr_neg(dr_neg), .fault(fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] result;
        logic         neg;
        logic         err;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   mode   = M_NORM;
    int   dly    = 0;
    int   bp_mode = 0;

    // ALU behaviour: {neg, result}
    function automatic logic [W:0] alu_fn(input logic [1:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
        logic [W-1:0] r;
        logic         n;
        case (op)
            2'd0:    begin r = a + b; n = r[W-1]; end
            2'd1:    begin r = a - b; n = (a < b); end
            2'd2:    begin r = a & b; n = a[0]; end
            default: begin r = a | b; n = a[0]; end
        endcase
        return {n, r};
    endfunction

    function automatic logic [2*W-1:0] enc(input logic [W-1:0] v);
        logic [2*W-1:0] e;
        e = '0;
        for (int i = 0; i < int'(W); i++) begin
            e[2*i+1] = v[i];
            e[2*i]   = ~v[i];
        end
        return e;
    endfunction

    function automatic exp_t expect_rsp(input logic [1:0] op, input logic [W-1:0] a,
                                        input logic [W-1:0] b, input int md);
        exp_t       e;
        logic [W:0] f;
        f = alu_fn(op, a, b);
        if (md == M_NEVER || md == M_ILL) begin
            e.result = '0;
            e.neg    = 1'b0;
            e.err    = 1'b1;
        end else begin
            e.result = f[W-1:0];
            e.neg    = op[1] ? 1'b0 : f[W];
            e.err    = 1'b0;
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- dual-rail ALU model ----------------
    int           cnt;
    bit           seen;
    logic [1:0]   c_op, l_op;
    logic [W-1:0] c_a, c_b, l_a, l_b;
    logic [W:0]   f_out;
    logic         present;

    always_comb begin
        c_a = '0;
        c_b = '0;
        for (int i = 0; i < int'(W); i++) begin
            c_a[i] = dr_a[2*i+1];
            c_b[i] = dr_b[2*i+1];
        end
        c_op = {dr_sel1[1], dr_sel0[1]};
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= 0;
            seen <= 1'b0;
            l_op <= '0;
            l_a  <= '0;
            l_b  <= '0;
        end else begin
            if (dr_sel0 == 2'b00) cnt <= 0;
            else if (cnt < 15) cnt <= cnt + 1;
            if (dr_sel0 != 2'b00) begin
                l_op <= c_op;
                l_a  <= c_a;
                l_b  <= c_b;
                if (mode == M_STUCK) seen <= 1'b1;
            end
        end
    end

    always_comb begin
        dr_result = '0;
        dr_neg    = 2'b00;
        if (dr_sel0 != 2'b00) begin
            f_out   = alu_fn(c_op, c_a, c_b);
            present = (mode != M_NEVER) && (cnt >= dly);
        end else begin
            f_out   = alu_fn(l_op, l_a, l_b);
            present = seen;
        end
        if (present) begin
            dr_result = enc(f_out[W-1:0]);
            dr_neg    = {f_out[W], ~f_out[W]};
            if (mode == M_ILL) dr_result[1:0] = 2'b11;
        end
    end

    // ---------------- response backpressure ----------------
    initial begin
        rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = 1'b0;
                default: rsp_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got result %0h err %0b with empty scoreboard",
                         rsp_result, rsp_err);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_result", 32'(rsp_result), 32'(e.result));
                check("rsp_neg", 32'(rsp_neg), 32'(e.neg));
                check("rsp_err", 32'(rsp_err), 32'(e.err));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("wait_req_ready", 32'(req_ready), 32'd1);
    endtask

    task automatic wait_rsp();
        int n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) check("wait_rsp_valid", 32'(rsp_valid), 32'd1);
    endtask

    task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int md, input int dl);
        wait_idle();
        mode      = md;
        dly       = dl;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        sb.push_back(expect_rsp(op, a, b, md));
    endtask

    initial begin
        exp_t snap;
        rst_n     = 1'b1;
        req_valid = 1'b0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        #2 rst_n = 1'b0;
        #2;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp", 32'({rsp_valid, rsp_err, rsp_neg, rsp_result}), 32'd0);
        check("rst_dr", 32'({dr_a, dr_b, dr_sel0, dr_sel1}), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Latency with zero-delay loopback: 3+2
        send(2'b00, 4'd3, 4'd2, M_NORM, 0);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 3) check("lat_no_rsp_e3", 32'(rsp_valid), 32'd0);
            if (k == 4) check("lat_rsp_e4", 32'(rsp_valid), 32'd1);
            if (k == 7) check("lat_busy_e7", 32'(req_ready), 32'd0);
            if (k == 8) check("lat_ready_e8", 32'(req_ready), 32'd1);
        end

        // Subtract 2-5: DATA encoding visible during EVAL
        send(2'b01, 4'd2, 4'd5, M_NORM, 0);
        @(negedge clk);
        check("eval_sel0", 32'(dr_sel0), 32'(2'b10));
        check("eval_sel1", 32'(dr_sel1), 32'(2'b01));
        check("eval_dr_a", 32'(dr_a), 32'(enc(4'd2)));
        check("eval_dr_b", 32'(dr_b), 32'(enc(4'd5)));

        // DATA never completes -> timeout error after TIMEOUT cycles
        send(2'b00, 4'd5, 4'd6, M_NEVER, 0);
        for (int k = 1; k <= int'(TIMEOUT) + 1; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == int'(TIMEOUT)) check("to_not_yet", 32'(rsp_valid), 32'd0);
        end
        check("to_rsp_valid", 32'(rsp_valid), 32'd1);
        check("to_rsp_err", 32'(rsp_err), 32'd1);
        check("to_dr_null", 32'({dr_a, dr_b, dr_sel0, dr_sel1}), 32'd0);
        check("to_busy", 32'(req_ready), 32'd0);

        // Illegal 11 pair on result
        send(2'b01, 4'd7, 4'd1, M_ILL, 0);
        wait_rsp();
        check("ill_err", 32'(rsp_err), 32'd1);
        check("ill_no_fault", 32'(fault), 32'd0);
        bp_mode = 1;

        // Response held under backpressure
        send(2'b10, 4'd9, 4'd12, M_NORM, 2);
        wait_rsp();
        snap = '{result: rsp_result, neg: rsp_neg, err: rsp_err};
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("hold_stable", 32'({rsp_valid, req_ready, rsp_result, rsp_neg, rsp_err}),
                  32'({1'b1, 1'b0, snap}));
        end
        check("hold_no_fault", 32'(fault), 32'd0);
        bp_mode = 0;
        for (int n = 0; n < 10 && !rsp_ready; n++) @(negedge clk);
        @(negedge clk);
        check("hold_release_idle", 32'(req_ready), 32'd1);

        // ALU stuck at DATA after capture -> sticky fault, no new accept
        send(2'b00, 4'd4, 4'd4, M_STUCK, 0);
        wait_rsp();
        repeat (40) @(negedge clk);
        check("stuck_fault", 32'(fault), 32'd1);
        check("stuck_busy", 32'(req_ready), 32'd0);
        check("stuck_sb_empty", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("stuck_rst_fault", 32'(fault), 32'd0);
        check("stuck_rst_ready", 32'(req_ready), 32'd1);
        mode = M_NORM;
        @(negedge clk);
        rst_n = 1'b1;

        // Async reset in the middle of EVAL
        send(2'b01, 4'd3, 4'd3, M_NEVER, 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_dr", 32'({dr_a, dr_b, dr_sel0, dr_sel1}), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd1);
        check("mid_rst_rsp", 32'({rsp_valid, rsp_err, rsp_neg, rsp_result}), 32'd0);
        sb.delete();
        mode = M_NORM;
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic with random backpressure and ALU delay
        bp_mode = 2;
        for (int t = 0; t < 40; t++) begin
            int r;
            int md;
            r  = $urandom_range(0, 19);
            md = (r == 0) ? M_NEVER : (r == 1) ? M_ILL : M_NORM;
            send(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), md, $urandom_range(0, 4));
        end
        bp_mode = 0;
        for (int n = 0; n < 300 && sb.size() != 0; n++) @(negedge clk);
        check("sb_drain", 32'(sb.size()), 32'd0);
        check("end_no_fault", 32'(fault), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
